// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-I subset control unit.
// Steps each instruction through fetch/decode/execute/memory/writeback.
// Drives the datapath mux selects and write enables, and sends aluop to
// the ALU in the ALU's own 3-bit encoding.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    // State encodings (visible on the state port)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPEEX  = 4'd6;
    localparam logic [3:0] S_RTYPEWB  = 4'd7;
    localparam logic [3:0] S_BRANCHEX = 4'd8;
    localparam logic [3:0] S_IMMEX    = 4'd9;
    localparam logic [3:0] S_IMMWB    = 4'd10;
    localparam logic [3:0] S_JEX      = 4'd11;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B operand selects
    localparam logic [1:0] B_REG   = 2'b00;
    localparam logic [1:0] B_FOUR  = 2'b01;
    localparam logic [1:0] B_IMM   = 2'b10;
    localparam logic [1:0] B_IMMSH = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [3:0] state_q, state_d;
    logic [3:0] out_st;
    logic       funct_ok;
    logic [2:0] rtype_aluop;
    logic       decode_ok;

    // R-type funct decode: legality and the matching ALU operation
    always_comb begin
        funct_ok    = 1'b1;
        rtype_aluop = ALU_ADD;
        case (funct)
            F_ADD, F_ADDU: rtype_aluop = ALU_ADD;
            F_SUB, F_SUBU: rtype_aluop = ALU_SUB;
            F_AND:         rtype_aluop = ALU_AND;
            F_OR:          rtype_aluop = ALU_OR;
            F_SLT:         rtype_aluop = ALU_SLT;
            default:       funct_ok    = 1'b0;
        endcase
    end

    // Instruction legality as seen in DECODE
    always_comb begin
        decode_ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_J: decode_ok = 1'b1;
            OP_RTYPE:               decode_ok = funct_ok;
            default:                decode_ok = 1'b0;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; unused codes 12-15 fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!decode_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW:     state_d = S_MEMADR;
                        OP_RTYPE:         state_d = S_RTYPEEX;
                        OP_BEQ, OP_BNE:   state_d = S_BRANCHEX;
                        OP_ADDI, OP_SLTI: state_d = S_IMMEX;
                        OP_J:             state_d = S_JEX;
                        default:          state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = S_FETCH;
            S_RTYPEEX:  state_d = S_RTYPEWB;
            S_RTYPEWB:  state_d = S_FETCH;
            S_BRANCHEX: state_d = S_FETCH;
            S_IMMEX:    state_d = S_IMMWB;
            S_IMMWB:    state_d = S_FETCH;
            S_JEX:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the outputs show FETCH, with its enables masked
    assign out_st = reset ? S_FETCH : state_q;
    assign state  = state_q;

    // Moore output decode; everything not set in a state stays 0
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = B_REG;
        aluop    = ALU_AND;
        pcsrc    = PC_ALURES;
        pcen     = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (out_st)
            S_FETCH: begin
                alusrcb = B_FOUR;
                aluop   = ALU_ADD;
                irwrite = ~reset;
                pcen    = ~reset;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here
                alusrcb = B_IMMSH;
                aluop   = ALU_ADD;
                illegal = ~decode_ok;
                retire  = ~decode_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = B_IMM;
                aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                alusrcb = B_REG;
                aluop   = rtype_aluop;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCHEX: begin
                alusrca = 1'b1;
                alusrcb = B_REG;
                aluop   = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = (op == OP_BNE) ? ~zero : zero;
                retire  = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = B_IMM;
                aluop   = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JEX: begin
                pcsrc  = PC_JUMP;
                pcen   = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control. The stimulus process
// expands each instruction into its expected per-cycle output records
// (from an instruction-level table) and queues them; a monitor pops one
// record per cycle and compares it with the DUT.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic       pcen, retire, illegal;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsrc(pcsrc), .pcen(pcen), .retire(retire), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen, retire, illegal;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Instruction-level reference tables
    int         op_kind [logic [5:0]];   // 1 lw 2 sw 3 R 4 beq 5 bne 6 addi 7 slti 8 j
    logic [2:0] rt_alu  [logic [5:0]];
    logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000101, 6'b001000, 6'b001010, 6'b000010};
    logic [5:0] legal_fn  [7] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                  6'b100100, 6'b100101, 6'b101010};

    function automatic rec_t blank(input logic [3:0] st);
        rec_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    // FETCH-looking record; enables only when not in reset
    function automatic rec_t fetch_rec(input logic [3:0] st, input logic en);
        rec_t r;
        r = blank(st);
        r.alusrcb = 2'b01;
        r.aluop   = 3'b010;
        r.irwrite = en;
        r.pcen    = en;
        return r;
    endfunction

    task automatic cyc(input rec_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction starting in FETCH; queue its whole expected trace
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
        rec_t e;
        int   k;
        op = o; funct = f; zero = z;
        k = op_kind.exists(o) ? op_kind[o] : 0;
        if (k == 3 && !rt_alu.exists(f)) k = 0;
        cyc(fetch_rec(4'd0, 1'b1));
        e = blank(4'd1);
        e.alusrcb = 2'b11;
        e.aluop   = 3'b010;
        if (k == 0) begin
            e.illegal = 1'b1;
            e.retire  = 1'b1;
            cyc(e);
            return;
        end
        cyc(e);
        case (k)
            1, 2: begin
                e = blank(4'd2); e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b010; cyc(e);
                if (k == 1) begin
                    e = blank(4'd3); e.iord = 1; cyc(e);
                    e = blank(4'd4); e.memtoreg = 1; e.regwrite = 1; e.retire = 1; cyc(e);
                end else begin
                    e = blank(4'd5); e.iord = 1; e.memwrite = 1; e.retire = 1; cyc(e);
                end
            end
            3: begin
                e = blank(4'd6); e.alusrca = 1; e.aluop = rt_alu[f]; cyc(e);
                e = blank(4'd7); e.regdst = 1; e.regwrite = 1; e.retire = 1; cyc(e);
            end
            4, 5: begin
                e = blank(4'd8); e.alusrca = 1; e.aluop = 3'b110; e.pcsrc = 2'b01;
                e.retire = 1; e.pcen = (k == 4) ? z : !z; cyc(e);
            end
            6, 7: begin
                e = blank(4'd9); e.alusrca = 1; e.alusrcb = 2'b10;
                e.aluop = (k == 7) ? 3'b111 : 3'b010; cyc(e);
                e = blank(4'd10); e.regwrite = 1; e.retire = 1; cyc(e);
            end
            default: begin
                e = blank(4'd11); e.pcsrc = 2'b10; e.pcen = 1; e.retire = 1; cyc(e);
            end
        endcase
    endtask

    // Monitor: one queued record per cycle, plus write-enable exclusivity
    always @(negedge clk) begin
        rec_t a, x;
        if (exp_q.size() > 0) begin
            cyc_no++;
            x = exp_q.pop_front();
            a = '{st: state, iord: iord, memwrite: memwrite, irwrite: irwrite,
                  regdst: regdst, memtoreg: memtoreg, regwrite: regwrite,
                  alusrca: alusrca, alusrcb: alusrcb, aluop: aluop, pcsrc: pcsrc,
                  pcen: pcen, retire: retire, illegal: illegal};
            n_checks++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL cycle_%0d outputs: got %h (state %0d) required %h (state %0d)",
                         cyc_no, a, a.st, x, x.st);
            end
            n_checks++;
            if ((32'(regwrite) + 32'(memwrite) + 32'(irwrite)) > 1) begin
                n_fail++;
                $display("FAIL cycle_%0d we_exclusive: got rw=%b mw=%b iw=%b required at most one",
                         cyc_no, regwrite, memwrite, irwrite);
            end
        end
    end

    initial begin
        rec_t e;
        logic [5:0] o, f;
        op_kind[6'b100011] = 1; op_kind[6'b101011] = 2; op_kind[6'b000000] = 3;
        op_kind[6'b000100] = 4; op_kind[6'b000101] = 5; op_kind[6'b001000] = 6;
        op_kind[6'b001010] = 7; op_kind[6'b000010] = 8;
        rt_alu[6'b100000] = 3'b010; rt_alu[6'b100001] = 3'b010;
        rt_alu[6'b100010] = 3'b110; rt_alu[6'b100011] = 3'b110;
        rt_alu[6'b100100] = 3'b000; rt_alu[6'b100101] = 3'b001;
        rt_alu[6'b101010] = 3'b111;

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        cyc(fetch_rec(4'd0, 1'b0));
        cyc(fetch_rec(4'd0, 1'b0));
        reset = 1'b0;

        // lw interrupted by a 3-cycle reset while in MEMRD
        op = 6'b100011; funct = '0;
        cyc(fetch_rec(4'd0, 1'b1));
        e = blank(4'd1); e.alusrcb = 2'b11; e.aluop = 3'b010; cyc(e);
        e = blank(4'd2); e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b010; cyc(e);
        reset = 1'b1;
        cyc(fetch_rec(4'd3, 1'b0));
        cyc(fetch_rec(4'd0, 1'b0));
        cyc(fetch_rec(4'd0, 1'b0));
        reset = 1'b0;

        // Directed instructions
        issue(6'b100011, 6'b000000, 1'b0);
        foreach (legal_fn[i]) issue(6'b000000, legal_fn[i], 1'b0);
        issue(6'b000100, 6'b000000, 1'b1);
        issue(6'b000100, 6'b000000, 1'b0);
        issue(6'b000101, 6'b000000, 1'b1);
        issue(6'b000101, 6'b000000, 1'b0);
        issue(6'b001010, 6'b000000, 1'b0);
        issue(6'b001000, 6'b000000, 1'b0);
        issue(6'b000010, 6'b000000, 1'b0);
        issue(6'b101011, 6'b000000, 1'b0);
        issue(6'b111111, 6'b000000, 1'b0);
        issue(6'b000000, 6'b000000, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            o = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 7)]
                                           : 6'($urandom_range(0, 63));
            f = ($urandom_range(0, 9) < 7) ? legal_fn[$urandom_range(0, 6)]
                                           : 6'($urandom_range(0, 63));
            issue(o, f, 1'($urandom_range(0, 1)));
        end

        // Let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d records left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle MIPS control unit and the initiator of the ALU's 3-bit aluop / zero-flag interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives datapath mux selects and write enables, and produces aluop directly in the ALU's encoding.
- Sits between the instruction register (op/funct) and the datapath: the ALU, register file, PC and memory.

Parameters:
- none. Opcode, funct and aluop encodings are fixed MIPS-I subset constants.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag (flagz)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  write data select: 0=ALUOut, 1=memory data
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0=PC, 1=regA
- alusrcb  output  2  ALU B select: 00=regB, 01=const 4, 10=signimm, 11=signimm<<2
- aluop  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- pcsrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- pcen  output  1  PC load enable
- retire  output  1  high during the final state of each instruction
- illegal  output  1  one-cycle pulse in DECODE for an unsupported op/funct
- state  output  4  current state encoding (debug/verification)

Behaviour:
- Moore FSM with a 4-bit registered state. All outputs are combinational from state, plus op/funct/zero where noted.
- Default for every output not listed in a state is 0.
- op/funct are stable from DECODE until the next FETCH, because irwrite is asserted only in FETCH.
- Reset:
  - reset=1 at a clock edge sets state to FETCH.
  - While reset=1, pcen, irwrite, memwrite, regwrite, retire and illegal are forced to 0; other outputs show FETCH values.
  - Reset mid-instruction abandons that instruction; no write enable is asserted after the reset edge until FETCH.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BRANCHEX=8, IMMEX=9, IMMWB=10, JEX=11
  - Codes 12-15 go to FETCH on the next edge with all enables 0.
- FETCH: alusrcb=01, aluop=010, irwrite=1, pcen=1 -> DECODE.
- DECODE: alusrcb=11, aluop=010, which precomputes the branch target into ALUOut. Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type), funct legal -> RTYPEEX
  - 000100 (beq) / 000101 (bne) -> BRANCHEX
  - 001000 (addi) / 001010 (slti) -> IMMEX
  - 000010 (j) -> JEX
  - any other op, or R-type with illegal funct -> FETCH, with illegal=1 and retire=1 (executes as a nop).
- MEMADR: alusrca=1, alusrcb=10, aluop=010 -> MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: memtoreg=1, regwrite=1, retire=1 -> FETCH.
- MEMWR: iord=1, memwrite=1, retire=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop from funct -> RTYPEWB.
  - 100000/100001 -> 010
  - 100010/100011 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
- RTYPEWB: regdst=1, regwrite=1, retire=1 -> FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, aluop=110, pcsrc=01, retire=1 -> FETCH.
  - pcen = zero for beq.
  - pcen = ~zero for bne.
- IMMEX: alusrca=1, alusrcb=10, aluop=010 for addi or 111 for slti -> IMMWB.
- IMMWB: regwrite=1, retire=1 -> FETCH.
- JEX: pcsrc=10, pcen=1, retire=1 -> FETCH.
- Latency (cycles, FETCH to retire inclusive):
  - lw 5; sw, R-type, addi, slti 4; beq, bne, j 3; illegal 2.
- Write-enable exclusivity: regwrite, memwrite and irwrite are never high in the same cycle, and never high in any code 12-15.

Test Plan:
- Reset high 3 cycles mid-MEMRD, then low -> state=0 at each reset edge with memwrite=regwrite=pcen=irwrite=0 throughout; first post-reset cycle shows FETCH outputs with pcen=1.
- op=100011 -> states 0,1,2,3,4; MEMRD iord=1; MEMWB memtoreg=1, regwrite=1, retire=1; then back to 0.
- op=000000, funct in {100000, 100010, 100100, 100101, 101010} -> RTYPEEX aluop = 010, 110, 000, 001, 111 respectively; RTYPEWB regdst=1, regwrite=1.
- op=000100 with zero=1, then zero=0; op=000101 with both -> BRANCHEX pcsrc=01, aluop=110; pcen = 1,0 for beq and 0,1 for bne.
- op=001010 -> IMMEX aluop=111, alusrcb=10; op=000010 -> JEX pcsrc=10, pcen=1, 3-cycle retire.
- op=111111, then op=000000 with funct=000000 -> DECODE illegal=1, retire=1, next state 0; no write enable ever asserted.
